// File: rtl/axis_video_mon_v2.sv
// axis_video_mon_v2: inline AXI4-Stream video monitor.
// The stream is forwarded combinationally. The monitor measures line length,
// frame height and frame rate, checks geometry against cfg_width/cfg_height,
// and keeps sticky error flags.
// Optional build macro AXIS_MON_STALL_CNT_EN adds per-frame stall/idle
// cycle counters (stall_cnt, idle_cnt).
module axis_video_mon_v2 #(
    parameter int TDATA_WIDTH = 48,
    parameter int TUSER_WIDTH = 1,
    parameter int SOF_BIT     = 0,
    parameter int CNT_WIDTH   = 16,
    parameter int FREQ_HZ     = 100000000
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    input  logic [CNT_WIDTH-1:0]   cfg_width,
    input  logic [CNT_WIDTH-1:0]   cfg_height,
    input  logic                   err_clr,
    output logic [CNT_WIDTH-1:0]   col,
    output logic [CNT_WIDTH-1:0]   col_min,
    output logic [CNT_WIDTH-1:0]   col_max,
    output logic [CNT_WIDTH-1:0]   line,
    output logic [31:0]            fps,
    output logic                   frame_done,
    output logic [3:0]             err
`ifdef AXIS_MON_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            idle_cnt
`endif
);

    localparam int WIN_W = (FREQ_HZ > 1) ? $clog2(FREQ_HZ) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(FREQ_HZ - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Zero-latency passthrough, independent of reset
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign s_axis_tready = m_axis_tready;

    logic beat, sof, eol;
    assign beat = s_axis_tvalid & m_axis_tready;
    assign sof  = beat & s_axis_tuser[SOF_BIT];
    assign eol  = beat & s_axis_tlast;

    state_t state_q, state_d;
    logic   pre_sof_beat, close_frame, count_beat, in_frame;

    logic [CNT_WIDTH-1:0] col_cnt_q, col_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [CNT_WIDTH-1:0] col_q, col_d, col_min_q, col_min_d;
    logic [CNT_WIDTH-1:0] col_max_q, col_max_d, line_q, line_d;
    logic [31:0]          fps_q, fps_d, fps_cnt_q, fps_cnt_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [3:0]           err_q, err_d;
    logic                 frame_done_q, frame_done_d;

    // A SOF beat starts counting from an empty frame, whatever came before it
    logic [CNT_WIDTH-1:0] col_base, line_base, min_base, max_base, len;
    assign col_base  = sof ? '0 : col_cnt_q;
    assign line_base = sof ? '0 : line_cnt_q;
    assign min_base  = sof ? '1 : run_min_q;
    assign max_base  = sof ? '0 : run_max_q;
    assign len       = sat_inc(col_base);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= WAIT_SOF;
        else        state_q <= state_d;
    end

    // Next-state: leave WAIT_SOF on the first SOF, then stay in frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof) state_d = IN_FRAME;
            IN_FRAME: state_d = IN_FRAME;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // FSM outputs: which beats are counted, which flag errors, which close a frame
    always_comb begin
        pre_sof_beat = 1'b0;
        close_frame  = 1'b0;
        count_beat   = 1'b0;
        in_frame     = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                pre_sof_beat = beat & ~sof;
                count_beat   = sof;
            end
            IN_FRAME: begin
                in_frame    = 1'b1;
                close_frame = sof;
                count_beat  = beat;
            end
            default: ;
        endcase
    end

    // Line/frame measurement, geometry checks and sticky errors
    always_comb begin
        col_cnt_d    = col_cnt_q;
        line_cnt_d   = line_cnt_q;
        run_min_d    = run_min_q;
        run_max_d    = run_max_q;
        col_d        = col_q;
        col_min_d    = col_min_q;
        col_max_d    = col_max_q;
        line_d       = line_q;
        frame_done_d = close_frame;
        err_d        = err_clr ? 4'b0000 : err_q;

        if (pre_sof_beat) err_d[3] = 1'b1;

        // The open line (if any) is dropped: only completed lines are reported
        if (close_frame) begin
            line_d    = line_cnt_q;
            col_min_d = run_min_q;
            col_max_d = run_max_q;
            if ((cfg_height != '0) && (line_cnt_q != cfg_height)) err_d[1] = 1'b1;
            if (col_cnt_q != '0) err_d[2] = 1'b1;
        end

        if (count_beat) begin
            if (eol) begin
                col_d      = len;
                col_cnt_d  = '0;
                line_cnt_d = sat_inc(line_base);
                run_min_d  = (len < min_base) ? len : min_base;
                run_max_d  = (len > max_base) ? len : max_base;
                if ((cfg_width != '0) && (len != cfg_width)) err_d[0] = 1'b1;
            end else begin
                col_cnt_d  = len;
                line_cnt_d = line_base;
                run_min_d  = min_base;
                run_max_d  = max_base;
            end
        end
    end

    // Frame-rate window: the SOF landing on the last window cycle still counts
    always_comb begin
        fps_d     = fps_q;
        fps_cnt_d = fps_cnt_q;
        win_cnt_d = win_cnt_q;
        if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            fps_d     = fps_cnt_q + {31'd0, sof};
            fps_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (sof) fps_cnt_d = fps_cnt_q + 32'd1;
        end
    end

    // Monitor registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            col_cnt_q    <= '0;
            line_cnt_q   <= '0;
            run_min_q    <= '1;
            run_max_q    <= '0;
            col_q        <= '0;
            col_min_q    <= '0;
            col_max_q    <= '0;
            line_q       <= '0;
            fps_q        <= '0;
            fps_cnt_q    <= '0;
            win_cnt_q    <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            line_cnt_q   <= line_cnt_d;
            run_min_q    <= run_min_d;
            run_max_q    <= run_max_d;
            col_q        <= col_d;
            col_min_q    <= col_min_d;
            col_max_q    <= col_max_d;
            line_q       <= line_d;
            fps_q        <= fps_d;
            fps_cnt_q    <= fps_cnt_d;
            win_cnt_q    <= win_cnt_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col        = col_q;
    assign col_min    = col_min_q;
    assign col_max    = col_max_q;
    assign line       = line_q;
    assign fps        = fps_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

`ifdef AXIS_MON_STALL_CNT_EN
    logic [31:0] stall_run_q, stall_run_d, idle_run_q, idle_run_d;
    logic [31:0] stall_cnt_q, stall_cnt_d, idle_cnt_q, idle_cnt_d;

    // Per-frame back-pressure and starvation counts, latched when the frame closes
    always_comb begin
        stall_run_d = stall_run_q;
        idle_run_d  = idle_run_q;
        stall_cnt_d = stall_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        if (close_frame) begin
            stall_cnt_d = stall_run_q;
            idle_cnt_d  = idle_run_q;
            stall_run_d = '0;
            idle_run_d  = '0;
        end else if (in_frame) begin
            if (s_axis_tvalid & ~m_axis_tready) stall_run_d = sat_inc32(stall_run_q);
            if (m_axis_tready & ~s_axis_tvalid) idle_run_d  = sat_inc32(idle_run_q);
        end
    end

    // Stall/idle registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_run_q <= '0;
            idle_run_q  <= '0;
            stall_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            stall_run_q <= stall_run_d;
            idle_run_q  <= idle_run_d;
            stall_cnt_q <= stall_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign idle_cnt  = idle_cnt_q;
`endif

endmodule

// File: tb/tb_axis_video_mon_v2.sv
// Directed testbench for axis_video_mon_v2 (FREQ_HZ reduced to 100).
module tb_axis_video_mon_v2;

    localparam int DW = 48;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic [0:0]    s_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [0:0]    m_axis_tuser;
    logic [CW-1:0] cfg_width, cfg_height;
    logic          err_clr;
    logic [CW-1:0] col, col_min, col_max, line;
    logic [31:0]   fps;
    logic          frame_done;
    logic [3:0]    err;
`ifdef AXIS_MON_STALL_CNT_EN
    logic [31:0]   stall_cnt, idle_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    int stalls;
    int idles;

    axis_video_mon_v2 #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(1), .SOF_BIT(0),
        .CNT_WIDTH(CW), .FREQ_HZ(100)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .err_clr(err_clr),
        .col(col), .col_min(col_min), .col_max(col_max), .line(line),
        .fps(fps), .frame_done(frame_done), .err(err)
`ifdef AXIS_MON_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .idle_cnt(idle_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One accepted beat with tready held high
    task automatic beat(input logic sof, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = sof;
        s_axis_tlast  = last;
        m_axis_tready = 1'b1;
        s_axis_tdata  = s_axis_tdata + 1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // n non-SOF beats, tlast on the final one
    task automatic line_rest(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, i == n - 1);
    endtask

    // One beat held valid until accepted, with up to 3 random stall cycles
    task automatic rbeat(input logic sof, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = sof;
        s_axis_tlast  = last;
        s_axis_tdata  = s_axis_tdata + 1;
        for (int n = 0; n < 4; n++) begin
            m_axis_tready = (n == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            if (m_axis_tready) break;
            stalls++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_col"}, 64'(col), 64'd0);
        chk({pfx, "_col_min"}, 64'(col_min), 64'd0);
        chk({pfx, "_col_max"}, 64'(col_max), 64'd0);
        chk({pfx, "_line"}, 64'(line), 64'd0);
        chk({pfx, "_fps"}, 64'(fps), 64'd0);
        chk({pfx, "_err"}, 64'(err), 64'd0);
        chk({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, got hang, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        s_axis_tdata = '0; m_axis_tready = 1'b1;
        cfg_width = 16'd8; cfg_height = 16'd4; err_clr = 1'b0;
        tick(); tick();

        // Passthrough while in reset
        s_axis_tdata = 48'hABCDEF012345; s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b1; s_axis_tuser = 1'b1; m_axis_tready = 1'b0;
        #1;
        chk("pt_tdata", 64'(m_axis_tdata), 64'hABCDEF012345);
        chk("pt_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("pt_tlast", 64'(m_axis_tlast), 64'd1);
        chk("pt_tuser", 64'(m_axis_tuser), 64'd1);
        chk("pt_tready", 64'(s_axis_tready), 64'd0);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk_outputs_zero("rst");
        areset = 1'b0;

        // Three 8x4 frames, continuous valid
        beat(1'b1, 1'b0); line_rest(7); line_rest(8); line_rest(8); line_rest(8);
        beat(1'b1, 1'b0);
        chk("f1_col", 64'(col), 64'd8);
        chk("f1_line", 64'(line), 64'd4);
        chk("f1_col_min", 64'(col_min), 64'd8);
        chk("f1_col_max", 64'(col_max), 64'd8);
        chk("f1_frame_done", 64'(frame_done), 64'd1);
        chk("f1_err", 64'(err), 64'd0);
        beat(1'b0, 1'b0);
        chk("f1_done_pulse", 64'(frame_done), 64'd0);
        line_rest(6); line_rest(8); line_rest(8); line_rest(8);
        beat(1'b1, 1'b0); line_rest(7); line_rest(8); line_rest(8); line_rest(8);
        beat(1'b1, 1'b0);
        chk("f3_line", 64'(line), 64'd4);
        chk("f3_frame_done", 64'(frame_done), 64'd1);
        chk("f3_err", 64'(err), 64'd0);

        // Short line (7 beats) in an 8x4 frame
        line_rest(7); line_rest(7);
        chk("short_col", 64'(col), 64'd7);
        line_rest(8); line_rest(8);
        beat(1'b1, 1'b0);
        chk("short_err", 64'(err), 64'b0001);
        chk("short_col_min", 64'(col_min), 64'd7);
        chk("short_col_max", 64'(col_max), 64'd8);
        chk("short_line", 64'(line), 64'd4);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_err", 64'(err), 64'd0);

        // SOF after 3 beats of an unterminated line (2 lines complete)
        line_rest(7); line_rest(8);
        beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        chk("midsof_err", 64'(err), 64'b0110);
        chk("midsof_line", 64'(line), 64'd2);
        chk("midsof_col_min", 64'(col_min), 64'd8);
        chk("midsof_col_max", 64'(col_max), 64'd8);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_err2", 64'(err), 64'd0);

        // Frame rate: 100-cycle window, SOF on every 20th cycle after reset
        do_reset();
        cfg_width = '0; cfg_height = '0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            s_axis_tvalid = (cyc % 20 == 0);
            s_axis_tuser  = 1'b1;
            s_axis_tlast  = 1'b1;
            m_axis_tready = 1'b1;
            tick();
            if (cyc == 99)  chk("fps_before_window", 64'(fps), 64'd0);
            if (cyc == 100) chk("fps_window1", 64'(fps), 64'd5);
            if (cyc == 200) chk("fps_window2", 64'(fps), 64'd5);
        end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        chk("fps_err", 64'(err), 64'd0);

        // 16x2 frame with random back-pressure and two idle cycles
        do_reset();
        cfg_width = 16'd16; cfg_height = 16'd2;
        stalls = 0; idles = 0;
        beat(1'b1, 1'b0);
        for (int c = 1; c < 16; c++) rbeat(1'b0, c == 15);
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        tick(); tick(); idles += 2;
        for (int c = 0; c < 16; c++) rbeat(1'b0, c == 15);
        rbeat(1'b1, 1'b0);
        chk("stall_col", 64'(col), 64'd16);
        chk("stall_line", 64'(line), 64'd2);
        chk("stall_col_min", 64'(col_min), 64'd16);
        chk("stall_col_max", 64'(col_max), 64'd16);
        chk("stall_err", 64'(err), 64'd0);
        chk("stall_frame_done", 64'(frame_done), 64'd1);
`ifdef AXIS_MON_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
        chk("idle_cnt", 64'(idle_cnt), 64'(idles));
`endif
        m_axis_tready = 1'b1;

        // Beats before the first SOF, then reset mid-frame
        do_reset();
        cfg_width = 16'd8; cfg_height = 16'd4;
        beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        chk("presof_err", 64'(err), 64'b1000);
        chk("presof_line", 64'(line), 64'd0);
        chk("presof_col", 64'(col), 64'd0);
        beat(1'b1, 1'b0); line_rest(7);
        chk("prerst_col", 64'(col), 64'd8);
        beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        s_axis_tvalid = 1'b1; areset = 1'b1;
        tick();
        areset = 1'b0; s_axis_tvalid = 1'b0;
        chk_outputs_zero("midrst");
        beat(1'b0, 1'b0);
        chk("midrst_wait_sof", 64'(err), 64'b1000);
        beat(1'b1, 1'b1);
        chk("first_sof_no_done", 64'(frame_done), 64'd0);
        chk("first_sof_line", 64'(line), 64'd0);
        chk("first_sof_col", 64'(col), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
